// File: rtl/tristate_xcvr.sv
// Bidirectional bus transceiver: registers one side onto the other with a
// counted dead-time window whenever the requested direction flips.
module tristate_xcvr #(
  parameter int WIDTH = 8,
  parameter int TURN  = 2
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] a,
  inout  wire  [WIDTH-1:0] b,
  input  logic             ctrl,
  input  logic             en,
  output logic             busy,
  output logic             dir,
  output logic [7:0]       turns
);

  localparam int CW = (TURN < 1) ? 1 : $clog2(TURN + 1);
  localparam logic [CW-1:0] TURN_CNT = CW'(TURN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_A2B, ST_B2A, ST_TURN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [7:0]       turns_q, turns_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dir_d   = dir_q;
    turns_d = turns_q;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d = ctrl ? ST_A2B : ST_B2A;
          dir_d   = ctrl;
          data_d  = ctrl ? a : b;
        end
      end
      ST_A2B, ST_B2A: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (ctrl != dir_q) begin
          state_d = ST_TURN;
          cnt_d   = TURN_CNT;
        end else begin
          data_d = dir_q ? a : b;
        end
      end
      ST_TURN: begin
        // Abandoning a turnaround does not count as a completed one.
        if (!en) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_ONE) begin
          state_d = ctrl ? ST_A2B : ST_B2A;
          dir_d   = ctrl;
          data_d  = ctrl ? a : b;
          turns_d = turns_q + 8'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      dir_q   <= 1'b0;
      turns_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dir_q   <= dir_d;
      turns_q <= turns_d;
    end
  end

  // Each bus has exactly one driving state, so they can never be driven together.
  assign a = (state_q == ST_B2A) ? data_q : {WIDTH{1'bz}};
  assign b = (state_q == ST_A2B) ? data_q : {WIDTH{1'bz}};

  assign busy  = (state_q == ST_TURN);
  assign dir   = dir_q;
  assign turns = turns_q;

endmodule
